data_bus_ctrl: RTL and testbench
================================

# data_bus_ctrl

Multi-cycle load/store sequencer between the single-cycle RV32I core and the data bus. It freezes the core with `stall` while a load or store runs a req/gnt/rvalid handshake on the bus. Stores get byte-lane enables and replicated data. Returned load data is aligned and sign/zero-extended and presented with a one-cycle `load_valid` that acts as the register-file write enable for `I_LOAD_TYPE` instructions. Misaligned or undefined accesses never reach the bus and are reported as `fault`.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus wait limit in cycles; used only with `BUS_TIMEOUT_EN`; legal range 1..65535.

- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `mem_req`  in  1  current instruction is a load/store
- `mem_we`  in  1  1 = store, 0 = load
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  32  effective byte address (ALU result)
- `store_data`  in  32  rs2 value
- `stall`  out  1  hold PC and core state
- `load_valid`  out  1  one-cycle rd write enable for the completed load
- `load_data`  out  32  extended load result; valid only with `load_valid`
- `fault`  out  1  one-cycle pulse: misaligned, illegal or timed-out access
- `bus_req`  out  1  transaction request, held until `bus_gnt`
- `bus_we`  out  1  store
- `bus_addr`  out  32  word address, `addr[31:2],2'b00`
- `bus_be`  out  4  byte-lane enables
- `bus_wrdata`  out  32  lane-replicated store data
- `bus_gnt`  in  1  request accepted
- `bus_rvalid`  in  1  read data valid
- `bus_rddata`  in  32  read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- IDLE with `mem_req=1`:
  - Legal access: register `bus_addr`, `bus_we`, `bus_be`, `bus_wrdata`, `addr[1:0]` and `funct3`; go to REQ.
  - Illegal access: go to DONE with `fault` pending; no bus activity.
- Illegal access is any of:
  - H with `addr[0]=1`
  - W with `addr[1:0]≠0`
  - `funct3` ∈ {011, 110, 111}
  - a store with `funct3` ∈ {100, 101}
- REQ: `bus_req=1`. On `bus_gnt`: a store goes to DONE; a load drops `bus_req` and goes to WAIT.
- WAIT: on `bus_rvalid`, capture the extended result and go to DONE. `bus_rvalid` is ignored in every other state.
- DONE: lasts one cycle, then IDLE. `mem_req` is ignored in DONE because it still belongs to the retiring instruction.
- `stall` is combinational: 1 in REQ and WAIT, and 1 in IDLE when `mem_req=1`. It is 0 in DONE and 0 while `rst=1`.
- Byte lanes:
  - SB: `be = 4'b0001 << addr[1:0]`, `wrdata = {4{sd[7:0]}}`.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, `wrdata = {2{sd[15:0]}}`.
  - SW: `be = 4'b1111`, `wrdata = sd`.
- Load extraction: `w = bus_rddata >> (8*addr[1:0])`, then:
  - LB: sign-extend `w[7:0]`
  - LH: sign-extend `w[15:0]`
  - LW: `w`
  - LBU: zero-extend `w[7:0]`
  - LHU: zero-extend `w[15:0]`
- DONE outputs:
  - `load_valid = 1` only for a successful load.
  - `fault = 1` only for an illegal or timed-out access.
  - Neither is asserted for a successful store.
- Reset mid-transaction: return to IDLE next edge, all registered outputs cleared. An outstanding `bus_rvalid` arriving afterwards is discarded.

## Timing
- Reset values: `bus_req`, `bus_we`, `load_valid`, `fault` = 0; `bus_addr`, `bus_be`, `bus_wrdata`, `load_data` = 0; `stall` = 0.
- All bus outputs are registered.
- Best-case load (gnt in first REQ cycle, rvalid next cycle): instruction occupies 4 cycles, stall high for 3. `load_valid` is in cycle 3 (cycle 0 = first IDLE cycle with `mem_req`).
- Best-case store: 3 cycles, stall high for 2.
- Illegal access: 2 cycles; `fault` in cycle 1.
- Each extra cycle without `bus_gnt`/`bus_rvalid` adds one stall cycle.
- Bus contract: `bus_rvalid` arrives no earlier than the cycle after `bus_gnt`.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to REQ or WAIT and increments each cycle there.
  - When it reaches `TIMEOUT_CYCLES` without the awaited `bus_gnt`/`bus_rvalid`, `bus_req` drops and the FSM goes to DONE with `fault=1` and `load_valid=0`.
  - A `bus_gnt`/`bus_rvalid` arriving in the same cycle as the limit wins over the timeout.
- Not defined: no counter. REQ and WAIT wait indefinitely; `fault` comes only from illegal accesses.

## Test plan
- LB at `addr=0x1003`, `bus_gnt` immediate, `bus_rddata=0x80FF_FF12` → `bus_addr=0x1000`, `bus_be=0000`, `load_valid` in cycle 3, `load_data=0xFFFF_FF80`. Same with LBU → `0x0000_0080`.
- SH at `addr=0x2002`, `store_data=0x1234_ABCD` → `bus_be=1100`, `bus_wrdata=0xABCD_ABCD`, `bus_we=1`, `stall` high for 2 cycles, no `load_valid`.
- LW at `addr=0x3001` → no `bus_req`, `fault=1` for one cycle, `stall` 1 then 0. Repeat with `funct3=011` → `fault`.
- LW with `bus_gnt` delayed 3 cycles and `bus_rvalid` delayed 2 more → `bus_req` held 4 cycles, `stall` high for 7 cycles, `load_data` equals `bus_rddata`.
- `rst` asserted while in WAIT, then `bus_rvalid=1` next cycle → IDLE, all outputs 0, no `load_valid`.
- `BUS_TIMEOUT_EN` with `TIMEOUT_CYCLES=4`, `bus_gnt` tied 0 → `bus_req` drops after 4 REQ cycles, `fault=1`, `stall` falls in the DONE cycle.

Source files
------------

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: multi-cycle load/store sequencer between the RV32I core and the data bus.
// Define BUS_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES cycles with a fault.
module data_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wrdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rddata
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        illegal_c;
    logic        tmo_c;
    logic [3:0]  be_c;
    logic [31:0] wrdata_c;
    logic [31:0] word_c;
    logic [31:0] ext_c;

    // Access legality: size/alignment and undefined funct3 codes
    always_comb begin
        illegal_c = 1'b0;
        case (funct3)
            3'b000:         illegal_c = 1'b0;
            3'b001:         illegal_c = addr[0];
            3'b010:         illegal_c = |addr[1:0];
            3'b100, 3'b101: illegal_c = mem_we;
            default:        illegal_c = 1'b1;
        endcase
    end

    // Store lane enables and replicated write data; loads drive no lanes
    always_comb begin
        be_c     = 4'b0000;
        wrdata_c = 32'h0;
        if (mem_we) begin
            case (funct3[1:0])
                2'b00: begin
                    be_c     = 4'b0001 << addr[1:0];
                    wrdata_c = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_c     = 4'b0011 << {addr[1], 1'b0};
                    wrdata_c = {2{store_data[15:0]}};
                end
                default: begin
                    be_c     = 4'b1111;
                    wrdata_c = store_data;
                end
            endcase
        end
    end

    // Load alignment and extension
    always_comb begin
        word_c = bus_rddata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext_c = {{24{word_c[7]}}, word_c[7:0]};
            3'b001:  ext_c = {{16{word_c[15]}}, word_c[15:0]};
            3'b100:  ext_c = {24'h0, word_c[7:0]};
            3'b101:  ext_c = {16'h0, word_c[15:0]};
            default: ext_c = word_c;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Wait counter restarts on every entry to REQ or WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) || (state_q == REQ && bus_gnt)) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic tmo_param_unused;

    assign tmo_param_unused = (TIMEOUT_CYCLES != 0);
    assign tmo_c            = 1'b0;
`endif

    assign stall = !rst && ((state_q == REQ) || (state_q == WAIT) ||
                            (state_q == IDLE && mem_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'b0000;
            bus_wrdata <= 32'h0;
            load_valid <= 1'b0;
            load_data  <= 32'h0;
            fault      <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        if (illegal_c) begin
                            fault   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            bus_req    <= 1'b1;
                            bus_we     <= mem_we;
                            bus_addr   <= {addr[31:2], 2'b00};
                            bus_be     <= be_c;
                            bus_wrdata <= wrdata_c;
                            off_q      <= addr[1:0];
                            f3_q       <= funct3;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state_q <= bus_we ? DONE : WAIT;
                    end else if (tmo_c) begin
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        load_data  <= ext_c;
                        load_valid <= 1'b1;
                        state_q    <= DONE;
                    end else if (tmo_c) begin
                        fault   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: directed loads/stores, faults, reset abort, optional timeout.
module tb_data_bus_ctrl;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wrdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rddata;

    always #5 clk = ~clk;

    data_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .store_data(store_data), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wrdata(bus_wrdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rddata(bus_rddata)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct packed {
        logic        is_fault;
        logic [31:0] data;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int        checks = 0;
    int        errors = 0;
    logic      prev_req = 1'b0;

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares each new bus request and each completion pulse against the queues
    always @(negedge clk) begin
        bus_exp_t  be_exp;
        resp_exp_t rs_exp;
        if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_bus_req: got addr %h expected none", bus_addr);
            end else begin
                be_exp = bus_q.pop_front();
                check32("bus_we", 32'(bus_we), 32'(be_exp.we));
                check32("bus_addr", bus_addr, be_exp.addr);
                check32("bus_be", 32'(bus_be), 32'(be_exp.be));
                check32("bus_wrdata", bus_wrdata, be_exp.wd);
            end
        end
        prev_req = bus_req;
        if (load_valid || fault) begin
            if (resp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: got lv=%0b fault=%0b expected none", load_valid, fault);
            end else begin
                rs_exp = resp_q.pop_front();
                check32("resp_fault", 32'(fault), 32'(rs_exp.is_fault));
                check32("resp_load_valid", 32'(load_valid), 32'(!rs_exp.is_fault));
                if (!rs_exp.is_fault) check32("load_data", load_data, rs_exp.data);
            end
        end
    end

    // One instruction: drives the bus responder, counts stall/bus_req cycles, checks DONE outputs
    task automatic run_access(
        input string name, input logic we, input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] sd, input int gnt_dly, input int rv_dly, input logic [31:0] rd,
        input int exp_stall, input int exp_breq, input logic exp_lv, input logic exp_flt,
        input logic [31:0] exp_baddr, input logic [3:0] exp_be, input logic [31:0] exp_wd,
        input logic [31:0] exp_data);
        int  nstall = 0;
        int  nreq   = 0;
        int  gnt_c  = -1;
        bit  done   = 1'b0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; store_data = sd; bus_rddata = rd;
        if (exp_breq > 0) bus_q.push_back('{we: we, addr: exp_baddr, be: exp_be, wd: exp_wd});
        if (exp_flt) resp_q.push_back('{is_fault: 1'b1, data: 32'h0});
        else if (exp_lv) resp_q.push_back('{is_fault: 1'b0, data: exp_data});
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            #1;
            if (stall) nstall++;
            if (bus_req) nreq++;
            if (c > 0 && !stall) begin
                done = 1'b1;
                check32({name, "_done_lv"}, 32'(load_valid), 32'(exp_lv));
                check32({name, "_done_fault"}, 32'(fault), 32'(exp_flt));
            end else begin
                if (bus_req && nreq == gnt_dly + 1) begin
                    bus_gnt = 1'b1;
                    gnt_c   = c;
                end
                if (!we && gnt_c >= 0 && c == gnt_c + rv_dly) bus_rvalid = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_hang: got no DONE expected DONE within 200 cycles", name);
        end
        check32({name, "_stall_cycles"}, 32'(nstall), 32'(exp_stall));
        check32({name, "_req_cycles"}, 32'(nreq), 32'(exp_breq));
        @(negedge clk);
        mem_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0;
        store_data = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rddata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_stall", 32'(stall), 32'h0);
        check32("rst_bus_req", 32'(bus_req), 32'h0);
        check32("rst_bus_we", 32'(bus_we), 32'h0);
        check32("rst_bus_addr", bus_addr, 32'h0);
        check32("rst_bus_be", 32'(bus_be), 32'h0);
        check32("rst_bus_wrdata", bus_wrdata, 32'h0);
        check32("rst_load_valid", 32'(load_valid), 32'h0);
        check32("rst_load_data", load_data, 32'h0);
        check32("rst_fault", 32'(fault), 32'h0);
        mem_req = 1'b0; rst = 1'b0;
        @(negedge clk);

        // name, we, f3, addr, sd, gnt_dly, rv_dly, rddata, stall, req, lv, flt, baddr, be, wd, data
        run_access("lb",   1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_FF12, 3, 1, 1'b1, 1'b0,
                   32'h0000_1000, 4'b0000, 32'h0, 32'hFFFF_FF80);
        run_access("lbu",  1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_FF12, 3, 1, 1'b1, 1'b0,
                   32'h0000_1000, 4'b0000, 32'h0, 32'h0000_0080);
        run_access("sh",   1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 32'h0, 2, 1, 1'b0, 1'b0,
                   32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 1, 32'h0, 1, 0, 1'b0, 1'b1,
                   32'h0, 4'b0000, 32'h0, 32'h0);
        run_access("f3_011", 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 1, 32'h0, 1, 0, 1'b0, 1'b1,
                   32'h0, 4'b0000, 32'h0, 32'h0);
        run_access("lw_slow", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 3, 2, 32'hCAFE_BABE, 7, 4, 1'b1, 1'b0,
                   32'h0000_3000, 4'b0000, 32'h0, 32'hCAFE_BABE);
        run_access("sb",   1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 1, 32'h0, 2, 1, 1'b0, 1'b0,
                   32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_access("lh",   1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_7FFF, 3, 1, 1'b1, 1'b0,
                   32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001);
        run_access("lhu",  1'b0, 3'b101, 32'h0000_2002, 32'h0, 1, 3, 32'h8001_7FFF, 6, 2, 1'b1, 1'b0,
                   32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001);
        run_access("sw",   1'b1, 3'b010, 32'h0000_0044, 32'h1122_3344, 2, 1, 32'h0, 4, 3, 1'b0, 1'b0,
                   32'h0000_0044, 4'b1111, 32'h1122_3344, 32'h0);
        run_access("sbu",  1'b1, 3'b100, 32'h0000_0040, 32'h0, 0, 1, 32'h0, 1, 0, 1'b0, 1'b1,
                   32'h0, 4'b0000, 32'h0, 32'h0);
        run_access("lh_mis", 1'b0, 3'b001, 32'h0000_1001, 32'h0, 0, 1, 32'h0, 1, 0, 1'b0, 1'b1,
                   32'h0, 4'b0000, 32'h0, 32'h0);
        run_access("lb_pos", 1'b0, 3'b000, 32'h0000_1001, 32'h0, 0, 1, 32'h0000_7F00, 3, 1, 1'b1, 1'b0,
                   32'h0000_1000, 4'b0000, 32'h0, 32'h0000_007F);

        // Reset while waiting for read data; the late rvalid must be dropped
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000; bus_rddata = 32'hDEAD_BEEF;
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_4000, be: 4'b0000, wd: 32'h0});
        @(negedge clk);
        #1;
        check32("abort_req", 32'(bus_req), 32'h1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        check32("abort_wait_stall", 32'(stall), 32'h1);
        rst = 1'b1; mem_req = 1'b0;
        #1;
        check32("abort_rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b1;
        #1;
        check32("abort_bus_req", 32'(bus_req), 32'h0);
        check32("abort_bus_addr", bus_addr, 32'h0);
        check32("abort_load_data", load_data, 32'h0);
        check32("abort_fault", 32'(fault), 32'h0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check32("abort_load_valid", 32'(load_valid), 32'h0);
        check32("abort_idle_stall", 32'(stall), 32'h0);
        @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        run_access("sw_tmo", 1'b1, 3'b010, 32'h0000_5000, 32'h5555_AAAA, 1000, 1, 32'h0, 5, 4, 1'b0, 1'b1,
                   32'h0000_5000, 4'b1111, 32'h5555_AAAA, 32'h0);
        run_access("lw_tmo", 1'b0, 3'b010, 32'h0000_6000, 32'h0, 0, 1000, 32'h0, 6, 1, 1'b0, 1'b1,
                   32'h0000_6000, 4'b0000, 32'h0, 32'h0);
`endif

        repeat (2) @(negedge clk);
        check32("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check32("resp_q_drained", 32'(resp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
